// File: rtl/ex_mem_buffer.sv
// ex_mem_buffer: two-entry elastic FIFO between execute and memory stages.
// Define EX_MEM_BRANCH_EN to store esBranch/pcBranch and resolve BEQ at the head.
module ex_mem_buffer #(
    parameter int ANCHO    = 32,
    parameter int REG_BITS = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                entValido,
    output logic                entListo,
    input  logic [ANCHO-1:0]    resultado,
    input  logic                zeroFlag,
    input  logic [ANCHO-1:0]    datoEscritura,
    input  logic [REG_BITS-1:0] regDestino,
    input  logic [2:0]          ctrlMem,
    input  logic                esBranch,
    input  logic [ANCHO-1:0]    pcBranch,
    input  logic                flush,
    output logic                salValido,
    input  logic                salListo,
    output logic [ANCHO-1:0]    salResultado,
    output logic                salZero,
    output logic [ANCHO-1:0]    salDato,
    output logic [REG_BITS-1:0] salRegDestino,
    output logic [2:0]          salCtrl,
    output logic                branchTomado,
    output logic [ANCHO-1:0]    pcDestino,
    output logic [1:0]          ocupacion
);
    logic [ANCHO-1:0]    res_q  [2];
    logic                zero_q [2];
    logic [ANCHO-1:0]    dato_q [2];
    logic [REG_BITS-1:0] rd_q   [2];
    logic [2:0]          ctrl_q [2];
    logic                wp_q, rp_q;
    logic [1:0]          cnt_q, cnt_d;
    logic                push, pop;

    assign entListo  = (cnt_q != 2'd2);
    assign salValido = (cnt_q != 2'd0);
    assign ocupacion = cnt_q;
    assign push      = entValido & entListo;
    assign pop       = salValido & salListo;

    always_comb begin
        cnt_d = (push && !pop) ? cnt_q + 2'd1 : (pop && !push) ? cnt_q - 2'd1 : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                res_q[i]  <= '0;
                zero_q[i] <= 1'b0;
                dato_q[i] <= '0;
                rd_q[i]   <= '0;
                ctrl_q[i] <= '0;
            end
            wp_q  <= 1'b0;
            rp_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else if (flush) begin
            wp_q  <= 1'b0;
            rp_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else begin
            if (push) begin
                res_q[wp_q]  <= resultado;
                zero_q[wp_q] <= zeroFlag;
                dato_q[wp_q] <= datoEscritura;
                rd_q[wp_q]   <= regDestino;
                ctrl_q[wp_q] <= ctrlMem;
                wp_q         <= ~wp_q;
            end
            if (pop)
                rp_q <= ~rp_q;
            cnt_q <= cnt_d;
        end
    end

    assign salResultado  = salValido ? res_q[rp_q]  : '0;
    assign salZero       = salValido ? zero_q[rp_q] : 1'b0;
    assign salDato       = salValido ? dato_q[rp_q] : '0;
    assign salRegDestino = salValido ? rd_q[rp_q]   : '0;
    assign salCtrl       = salValido ? ctrl_q[rp_q] : '0;

`ifdef EX_MEM_BRANCH_EN
    logic             br_q  [2];
    logic [ANCHO-1:0] pcb_q [2];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                br_q[i]  <= 1'b0;
                pcb_q[i] <= '0;
            end
        end else if (!flush && push) begin
            br_q[wp_q]  <= esBranch;
            pcb_q[wp_q] <= pcBranch;
        end
    end

    assign branchTomado = salValido & br_q[rp_q] & zero_q[rp_q];
    assign pcDestino    = branchTomado ? pcb_q[rp_q] : '0;
`else
    logic unused_branch;
    assign unused_branch = ^{esBranch, pcBranch};
    assign branchTomado  = 1'b0;
    assign pcDestino     = '0;
`endif
endmodule

// File: tb/tb_ex_mem_buffer.sv
// tb_ex_mem_buffer: directed vector table, corner sequences and randomized
// traffic compared against a queue model of the buffer.
module tb_ex_mem_buffer;
    logic        clk = 1'b0;
    logic        reset, entValido, entListo, zeroFlag, esBranch, flush;
    logic        salValido, salListo, salZero, branchTomado;
    logic [31:0] resultado, datoEscritura, pcBranch, salResultado, salDato, pcDestino;
    logic [4:0]  regDestino, salRegDestino;
    logic [2:0]  ctrlMem, salCtrl;
    logic [1:0]  ocupacion;

    int checks = 0;
    int errors = 0;

    ex_mem_buffer #(.ANCHO(32), .REG_BITS(5)) dut (
        .clk(clk), .reset(reset), .entValido(entValido), .entListo(entListo),
        .resultado(resultado), .zeroFlag(zeroFlag), .datoEscritura(datoEscritura),
        .regDestino(regDestino), .ctrlMem(ctrlMem), .esBranch(esBranch),
        .pcBranch(pcBranch), .flush(flush), .salValido(salValido), .salListo(salListo),
        .salResultado(salResultado), .salZero(salZero), .salDato(salDato),
        .salRegDestino(salRegDestino), .salCtrl(salCtrl), .branchTomado(branchTomado),
        .pcDestino(pcDestino), .ocupacion(ocupacion)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic        zero;
        logic [31:0] dato;
        logic [4:0]  rd;
        logic [2:0]  ctrl;
        logic        esb;
        logic [31:0] pcb;
    } ent_t;

    typedef struct {
        bit          ev, sl, fl;
        logic [31:0] res;
        logic [4:0]  rd;
        logic [1:0]  occ;
        bit          sv, el;
        logic [31:0] eres;
        logic [4:0]  erd;
    } vec_t;

    ent_t q[$];
    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit ev, input bit sl, input bit fl, input ent_t e);
        entValido = ev; salListo = sl; flush = fl;
        resultado = e.res; zeroFlag = e.zero; datoEscritura = e.dato;
        regDestino = e.rd; ctrlMem = e.ctrl; esBranch = e.esb; pcBranch = e.pcb;
    endtask

    // Model of one clock edge, evaluated on the pre-edge contents of q.
    task automatic model_edge(input bit ev, input bit sl, input bit fl, input ent_t e);
        bit can_push, can_pop;
        can_push = ev && (q.size() < 2);
        can_pop  = sl && (q.size() > 0);
        if (fl) q.delete();
        else begin
            if (can_pop) void'(q.pop_front());
            if (can_push) q.push_back(e);
        end
    endtask

    task automatic cmp_all(input string tag);
        ent_t h;
        bit sv, br;
        h = '{default: '0};
        sv = (q.size() != 0);
        if (sv) h = q[0];
`ifdef EX_MEM_BRANCH_EN
        br = sv && h.esb && h.zero;
`else
        br = 1'b0;
`endif
        chk({tag, ".entListo"}, entListo, q.size() != 2);
        chk({tag, ".salValido"}, salValido, sv);
        chk({tag, ".ocupacion"}, ocupacion, q.size());
        chk({tag, ".salResultado"}, salResultado, h.res);
        chk({tag, ".salZero"}, salZero, h.zero);
        chk({tag, ".salDato"}, salDato, h.dato);
        chk({tag, ".salRegDestino"}, salRegDestino, h.rd);
        chk({tag, ".salCtrl"}, salCtrl, h.ctrl);
        chk({tag, ".branchTomado"}, branchTomado, br);
        chk({tag, ".pcDestino"}, pcDestino, br ? h.pcb : 32'h0);
    endtask

    function automatic vec_t mk(bit ev, bit sl, bit fl, logic [31:0] res, logic [4:0] rd,
                                logic [1:0] occ, bit sv, bit el, logic [31:0] eres, logic [4:0] erd);
        return '{ev, sl, fl, res, rd, occ, sv, el, eres, erd};
    endfunction

    function automatic ent_t rnd_ent();
        ent_t e;
        e.res = $urandom; e.zero = 1'($urandom); e.dato = $urandom;
        e.rd = 5'($urandom); e.ctrl = 3'($urandom); e.esb = 1'($urandom);
        e.pcb = $urandom;
        return e;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        q.delete();
    endtask

    initial begin
        ent_t e, z;
        bit ev, sl, fl;
        z = '{default: '0};
        reset = 1'b1;
        drive(0, 0, 0, z);
        step();
        reset = 1'b0;
        cmp_all("reset");

        // single push, then drain
        tbl.push_back(mk(1, 1, 0, 32'h5, 5'd3, 2'd1, 1, 1, 32'h5, 5'd3));
        tbl.push_back(mk(0, 1, 0, 32'h0, 5'd0, 2'd0, 0, 1, 32'h0, 5'd0));
        // stall: A, B fill the buffer; C is refused; then A, B drain in order
        tbl.push_back(mk(1, 0, 0, 32'h11, 5'd1, 2'd1, 1, 1, 32'h11, 5'd1));
        tbl.push_back(mk(1, 0, 0, 32'h22, 5'd2, 2'd2, 1, 0, 32'h11, 5'd1));
        tbl.push_back(mk(1, 0, 0, 32'h33, 5'd3, 2'd2, 1, 0, 32'h11, 5'd1));
        tbl.push_back(mk(0, 1, 0, 32'h0, 5'd0, 2'd1, 1, 1, 32'h22, 5'd2));
        tbl.push_back(mk(0, 1, 0, 32'h0, 5'd0, 2'd0, 0, 1, 32'h0, 5'd0));
        // streaming 1..8 with salListo held high
        for (int i = 1; i <= 8; i++)
            tbl.push_back(mk(1, 1, 0, 32'(i), 5'(i), 2'd1, 1, 1, 32'(i), 5'(i)));
        tbl.push_back(mk(0, 1, 0, 32'h0, 5'd0, 2'd0, 0, 1, 32'h0, 5'd0));
        // fill, then flush while offering an entry
        tbl.push_back(mk(1, 0, 0, 32'hA1, 5'd4, 2'd1, 1, 1, 32'hA1, 5'd4));
        tbl.push_back(mk(1, 0, 0, 32'hA2, 5'd5, 2'd2, 1, 0, 32'hA1, 5'd4));
        tbl.push_back(mk(1, 1, 1, 32'hA3, 5'd6, 2'd0, 0, 1, 32'h0, 5'd0));
        tbl.push_back(mk(0, 0, 0, 32'h0, 5'd0, 2'd0, 0, 1, 32'h0, 5'd0));

        for (int i = 0; i < tbl.size(); i++) begin
            e = z;
            e.res = tbl[i].res; e.dato = tbl[i].res; e.rd = tbl[i].rd;
            drive(tbl[i].ev, tbl[i].sl, tbl[i].fl, e);
            step();
            chk($sformatf("vec%0d.ocupacion", i), ocupacion, tbl[i].occ);
            chk($sformatf("vec%0d.salValido", i), salValido, tbl[i].sv);
            chk($sformatf("vec%0d.entListo", i), entListo, tbl[i].el);
            chk($sformatf("vec%0d.salResultado", i), salResultado, tbl[i].eres);
            chk($sformatf("vec%0d.salRegDestino", i), salRegDestino, tbl[i].erd);
        end

        // branch resolution: taken, then not taken
        do_reset();
        e = z; e.res = 32'h0; e.zero = 1'b1; e.esb = 1'b1; e.pcb = 32'h40;
        drive(1, 0, 0, e); model_edge(1, 0, 0, e); step();
`ifdef EX_MEM_BRANCH_EN
        chk("beq_taken.branchTomado", branchTomado, 1'b1);
        chk("beq_taken.pcDestino", pcDestino, 32'h40);
`else
        chk("beq_taken.branchTomado", branchTomado, 1'b0);
        chk("beq_taken.pcDestino", pcDestino, 32'h0);
`endif
        cmp_all("beq_taken");
        e.zero = 1'b0; e.res = 32'h7;
        drive(1, 1, 0, e); model_edge(1, 1, 0, e); step();
        chk("beq_not.branchTomado", branchTomado, 1'b0);
        chk("beq_not.pcDestino", pcDestino, 32'h0);
        cmp_all("beq_not");

        // reset while full with the sink ready
        do_reset();
        for (int i = 0; i < 2; i++) begin
            e = rnd_ent();
            drive(1, 0, 0, e); model_edge(1, 0, 0, e); step();
        end
        cmp_all("full");
        reset = 1'b1;
        drive(1, 1, 1, rnd_ent());
        step();
        reset = 1'b0;
        q.delete();
        cmp_all("mid_reset");

        // randomized traffic against the queue model
        drive(0, 0, 0, z);
        for (int n = 0; n < 500; n++) begin
            e  = rnd_ent();
            ev = ($urandom_range(0, 3) != 0);
            sl = ($urandom_range(0, 2) != 0);
            fl = ($urandom_range(0, 29) == 0);
            drive(ev, sl, fl, e);
            model_edge(ev, sl, fl, e);
            step();
            cmp_all($sformatf("rnd%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
